sw_tx_arbiter: RTL and testbench
================================

SW_TX_ARBITER -- requirements
Module: sw_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of requester streams.
REQ-002 SHALL have parameter DW, default 169, stream data width (switch flit width).
REQ-003 SHALL have parameter BURST, default 16, beats per grant.
REQ-004 SHALL have parameter TMO, default 8, idle cycles before early release (REQ-024 only).
REQ-005 SHALL have ports: clk in 1, sole clock; ap_rst in 1, reset, synchronous, active-high.
REQ-006 SHALL have ports: ap_start in 1, start pulse; slot_en in 1, TDM slot open for this port.
REQ-007 SHALL have ports: req_valid in NREQ; req_data in NREQ*DW, requester i at bits [i*DW +: DW]; req_ready out NREQ.
REQ-008 SHALL have ports: out_valid out 1; out_data out DW; out_ready in 1, switch port handshake.
REQ-009 SHALL have ports: grant out 2, current grantee index; busy out 1, high in ARB/XFER.

Function
REQ-010 SHALL implement FSM IDLE, ARB, XFER.
REQ-011 In IDLE, ap_start=1 SHALL move to ARB next cycle; all other inputs ignored.
REQ-012 In ARB, slot_en=1 with any req_valid SHALL select the first valid requester scanning from (last+1) mod NREQ, load grant, clear beat counter, enter XFER.
REQ-013 In ARB, slot_en=0 or no req_valid SHALL remain in ARB.
REQ-014 In XFER, out_valid SHALL equal req_valid[grant] AND slot_en; out_data SHALL equal req_data[grant] combinationally (zero latency).
REQ-015 In XFER, req_ready[grant] SHALL equal out_ready AND slot_en; every other req_ready bit SHALL be 0.
REQ-016 Outside XFER, out_valid and all req_ready SHALL be 0.
REQ-017 A beat SHALL be out_valid AND out_ready; each beat SHALL increment the beat counter, width clog2(BURST+1).
REQ-018 On the BURST-th beat, SHALL set last=grant and return to ARB next cycle; the beat SHALL complete normally.
REQ-019 slot_en falling mid-burst SHALL pause transfer without losing the grant or the count; the burst SHALL resume when slot_en rises.
REQ-020 A simultaneous request from the grantee and others on burst end SHALL grant the next index (round robin); a sole requester MAY be re-granted in consecutive bursts.
REQ-021 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-022 ap_rst=1 at a clock edge SHALL force IDLE, grant=0, last=NREQ-1, beat counter=0, busy=0, out_valid=0, req_ready=0; this SHALL apply in any state, including mid-burst, with the partial burst abandoned.

Configuration
REQ-023 Macro SWARB_TIMEOUT_EN SHALL select early release.
REQ-024 With SWARB_TIMEOUT_EN defined, in XFER, TMO consecutive cycles with slot_en=1 and req_valid[grant]=0 SHALL set last=grant and return to ARB; the idle counter SHALL clear on any beat or on slot_en=0.
REQ-025 Without SWARB_TIMEOUT_EN, the grant SHALL be held until BURST beats complete, and no idle counter logic SHALL exist.

Structure
REQ-026 Package sw_arb_pkg SHALL hold the FSM state enum and default constants (DW=169, BURST=16, TMO=8).
REQ-027 The round-robin priority pick SHALL be a sub-module rr_pick (inputs: request vector, last; outputs: index, found); the FSM, counters and muxing SHALL be in the top module.

Verification
REQ-028 Reset and start: ap_start, req_valid=3'b111, slot_en=1, out_ready=1 -> grants 0,1,2,0 in turn, each exactly 16 beats; out_valid=1 one cycle after ARB.
REQ-029 Slot pause: slot_en=0 for 5 cycles after beat 7 of a burst -> out_valid=0 and req_ready=0 during the pause; beats 8..16 then continue on the same grant; total beats =16.
REQ-030 Backpressure: out_ready toggling 1,0 -> 16 beats take 32 cycles; no data duplicated or dropped (scoreboard by requester).
REQ-031 Mid-burst reset: ap_rst at beat 5 of grant 1 -> next cycle IDLE, all outputs 0; after ap_start, first grant =0.
REQ-032 Timeout, macro on: grantee drops valid after 3 beats -> return to ARB after 8 idle cycles, next requester granted; macro off -> grant held until beat 16.
REQ-033 Sole requester: only req_valid[2]=1 -> consecutive bursts all grant=2 with one ARB cycle between them.

Source files
------------

// File: rtl/sw_arb_pkg.sv
// Shared types and default sizing for the switch transmit arbiter.
package sw_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2
    } sw_arb_state_e;

    localparam int DEF_NREQ  = 3;
    localparam int DEF_DW    = 169;
    localparam int DEF_BURST = 16;
    localparam int DEF_TMO   = 8;

endpackage

// File: rtl/sw_tx_arbiter_rr_pick.sv
// Round-robin pick: first asserted request scanning upward from (last+1) mod NREQ.
module rr_pick #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic [1:0]      idx,
    output logic            found
);

    // Outer loop is the priority order, so the earliest offset wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && ((int'(last) + k) % NREQ) == i) begin
                    found = 1'b1;
                    idx   = 2'(i);
                end
            end
        end
    end

endmodule

// File: rtl/sw_tx_arbiter.sv
// Burst-based round-robin arbiter feeding one TDM switch port.
// Define SWARB_TIMEOUT_EN to release a grant early after TMO idle cycles.
//
// state | meaning
// IDLE  | waiting for ap_start
// ARB   | waiting for an open slot and a request; picks next grantee
// XFER  | streaming up to BURST beats from the grantee
module sw_tx_arbiter
    import sw_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int DW    = DEF_DW,
    parameter int BURST = DEF_BURST,
    parameter int TMO   = DEF_TMO
) (
    input  logic              clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    input  logic              slot_en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    input  logic              out_ready,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_ARB  = ST_ARB;
    localparam logic [1:0] S_XFER = ST_XFER;

    localparam int            BW        = $clog2(BURST + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
    localparam logic [1:0]    LAST_RST  = 2'(NREQ - 1);

    if (NREQ < 1 || NREQ > 4 || BURST < 1 || TMO < 1) begin : g_bad_param
        $error("sw_tx_arbiter: unsupported parameter set");
    end

    logic [1:0]    state;
    logic [1:0]    last;
    logic [1:0]    pick_idx;
    logic          pick_found;
    logic [BW-1:0] beat_cnt;
    logic          in_xfer;
    logic          sel_valid;
    logic [DW-1:0] sel_data;
    logic          beat;
    logic          tmo_hit;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_valid),
        .last  (last),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == 2'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[i*DW +: DW];
            end
        end
    end

    assign in_xfer   = (state == S_XFER);
    assign out_valid = in_xfer & sel_valid & slot_en;
    assign out_data  = out_valid ? sel_data : '0;
    assign beat      = out_valid & out_ready;
    assign busy      = (state != S_IDLE);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = in_xfer && (grant == 2'(i)) && out_ready && slot_en;
        end
    end

`ifdef SWARB_TIMEOUT_EN
    localparam int            IW        = $clog2(TMO + 1);
    localparam logic [IW-1:0] LAST_IDLE = IW'(TMO - 1);

    logic [IW-1:0] idle_cnt;
    logic          idle_cyc;

    // A stalled-but-valid cycle or a closed slot breaks the idle run.
    assign idle_cyc = in_xfer & slot_en & ~sel_valid;
    assign tmo_hit  = idle_cyc && (idle_cnt == LAST_IDLE);

    always_ff @(posedge clk) begin
        if (ap_rst || !idle_cyc || tmo_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (ap_rst) begin
            state    <= S_IDLE;
            grant    <= '0;
            last     <= LAST_RST;
            beat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) state <= S_ARB;
                end
                S_ARB: begin
                    if (slot_en && pick_found) begin
                        grant    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            last  <= grant;
                            state <= S_ARB;
                        end
                    end else if (tmo_hit) begin
                        last  <= grant;
                        state <= S_ARB;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sw_tx_arbiter.sv
// Directed and random checks of sw_tx_arbiter against a transaction-level model.
module tb_sw_tx_arbiter;

    localparam int NREQ  = 3;
    localparam int DW    = 169;
    localparam int BURST = 16;
    localparam int TMO   = 8;

    logic              clk = 1'b0;
    logic              ap_rst, ap_start, slot_en, out_ready;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [1:0]        grant;
    logic              busy;

    logic [DW-1:0] word [NREQ];

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = word[i];
    end

    sw_tx_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST), .TMO(TMO)) dut (
        .clk       (clk),
        .ap_rst    (ap_rst),
        .ap_start  (ap_start),
        .slot_en   (slot_en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    typedef enum {M_OFF, M_WAIT_SLOT, M_SENDING} mphase_e;

    int      checks = 0;
    int      failures = 0;
    mphase_e m_ph;
    int      m_g, m_last, m_beats, m_idle;
    int      mdl_taken [NREQ];
    int      dut_taken [NREQ];
    int      win_beats [NREQ];
    int      win_gaps;

    function automatic logic [DW-1:0] rand_word();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    function automatic int rr_next(logic [NREQ-1:0] v, int last);
        for (int k = 1; k <= NREQ; k++)
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_win();
        for (int i = 0; i < NREQ; i++) win_beats[i] = 0;
        win_gaps = 0;
    endtask

    // One clock: check outputs against the model, advance the model, move to the next negedge.
    task automatic cycle();
        logic            e_ov;
        logic [DW-1:0]   e_od;
        logic [NREQ-1:0] e_rr;
        logic [NREQ-1:0] hs;
        logic            m_beat;
        #1;
        e_ov = (m_ph == M_SENDING) && req_valid[m_g] && slot_en;
        e_od = e_ov ? word[m_g] : '0;
        e_rr = (m_ph == M_SENDING && out_ready && slot_en) ? NREQ'(1 << m_g) : '0;
        chk("busy", busy, m_ph != M_OFF);
        chk("grant", grant, m_g);
        chk("out_valid", out_valid, e_ov);
        chk("out_data", out_data, e_od);
        chk("req_ready", req_ready, e_rr);
        if (out_valid === 1'b1 && out_ready) begin
            dut_taken[grant]++;
            win_beats[grant]++;
        end
        if (out_valid !== 1'b1) win_gaps++;
        hs = req_ready & req_valid;

        m_beat = e_ov && out_ready;
        if (m_beat) mdl_taken[m_g]++;
        if (ap_rst) begin
            m_ph = M_OFF; m_g = 0; m_last = NREQ - 1; m_beats = 0; m_idle = 0;
        end else begin
            case (m_ph)
                M_OFF: if (ap_start) m_ph = M_WAIT_SLOT;
                M_WAIT_SLOT: begin
                    if (slot_en && req_valid != '0) begin
                        m_g = rr_next(req_valid, m_last);
                        m_beats = 0; m_idle = 0; m_ph = M_SENDING;
                    end
                end
                M_SENDING: begin
                    if (m_beat) begin
                        m_beats++; m_idle = 0;
                        if (m_beats == BURST) begin m_last = m_g; m_ph = M_WAIT_SLOT; end
                    end
`ifdef SWARB_TIMEOUT_EN
                    else if (slot_en && !req_valid[m_g]) begin
                        m_idle++;
                        if (m_idle == TMO) begin m_last = m_g; m_idle = 0; m_ph = M_WAIT_SLOT; end
                    end else m_idle = 0;
`endif
                end
                default: m_ph = M_OFF;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) if (hs[i]) word[i] = rand_word();
    endtask

    task automatic restart();
        ap_rst = 1'b1;
        cycle();
        ap_rst = 1'b0;
        ap_start = 1'b1;
        cycle();
        ap_start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            word[i] = rand_word(); mdl_taken[i] = 0; dut_taken[i] = 0;
        end
        clear_win();
        ap_rst = 1'b1; ap_start = 1'b0; slot_en = 1'b0; out_ready = 1'b0; req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        m_ph = M_OFF; m_g = 0; m_last = NREQ - 1; m_beats = 0; m_idle = 0;
        ap_rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_ready", req_ready, 0);

        // Round robin over three always-valid requesters
        req_valid = 3'b111; slot_en = 1'b1; out_ready = 1'b1;
        restart();
        clear_win();
        for (int c = 0; c < 4 * (BURST + 1); c++) begin
            if (c % (BURST + 1) == 1) begin
                #1;
                chk("rr_order", grant, (c / (BURST + 1)) % NREQ);
                chk("rr_first_valid", out_valid, 1);
            end
            cycle();
        end
        chk("rr_beats_g0", win_beats[0], 2 * BURST);
        chk("rr_beats_g1", win_beats[1], BURST);
        chk("rr_beats_g2", win_beats[2], BURST);

        // Slot closes for 5 cycles after beat 7
        restart();
        clear_win();
        for (int n = 0; n < 100 && !(m_ph == M_SENDING && m_beats == 7); n++) cycle();
        chk("pause_reach", win_beats[0], 7);
        slot_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("pause_out_valid", out_valid, 0);
            chk("pause_req_ready", req_ready, 0);
            cycle();
        end
        slot_en = 1'b1;
        for (int n = 0; n < 100 && m_ph != M_WAIT_SLOT; n++) cycle();
        chk("pause_total", win_beats[0], BURST);
        chk("pause_other", win_beats[1] + win_beats[2], 0);

        // Backpressure: out_ready alternates 1,0
        restart();
        clear_win();
        cycle();
        for (int c = 0; c < 2 * BURST; c++) begin
            out_ready = (c % 2 == 0);
            if (c == 2 * BURST - 1) begin
                #1;
                chk("bp_end_gap", out_valid, 0);
            end
            cycle();
        end
        chk("bp_beats", win_beats[0], BURST);
        out_ready = 1'b1;

        // Reset at beat 5 of grant 1
        restart();
        for (int n = 0; n < 200 && !(m_ph == M_SENDING && m_g == 1 && m_beats == 5); n++) cycle();
        #1;
        chk("mrst_reach", grant, 1);
        ap_rst = 1'b1;
        cycle();
        ap_rst = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_req_ready", req_ready, 0);
        chk("mrst_grant", grant, 0);
        ap_start = 1'b1;
        cycle();
        ap_start = 1'b0;
        cycle();
        #1;
        chk("mrst_regrant", grant, 0);
        chk("mrst_regrant_valid", out_valid, 1);

        // Grantee drops valid after 3 beats
        req_valid = 3'b011;
        restart();
        clear_win();
        for (int n = 0; n < 50 && !(m_ph == M_SENDING && m_beats == 3); n++) cycle();
        req_valid = 3'b010;
        for (int c = 0; c < 12; c++) cycle();
        #1;
`ifdef SWARB_TIMEOUT_EN
        chk("tmo_next_grant", grant, 1);
        chk("tmo_g0_beats", win_beats[0], 3);
`else
        chk("tmo_held_grant", grant, 0);
        req_valid = 3'b011;
        for (int n = 0; n < 100 && m_ph != M_WAIT_SLOT; n++) cycle();
        chk("tmo_held_beats", win_beats[0], BURST);
`endif

        // Sole requester 2 is re-granted with a single gap cycle
        req_valid = 3'b100;
        restart();
        clear_win();
        for (int c = 0; c < 3 * (BURST + 1); c++) cycle();
        chk("sole_beats_g2", win_beats[2], 3 * BURST);
        chk("sole_beats_other", win_beats[0] + win_beats[1], 0);
        chk("sole_gaps", win_gaps, 3);

        // Random traffic
        restart();
        for (int c = 0; c < 1500; c++) begin
            ap_rst    = ($urandom_range(63) == 0);
            ap_start  = ($urandom_range(7) == 0);
            slot_en   = ($urandom_range(7) != 0);
            out_ready = ($urandom_range(3) != 0);
            req_valid = NREQ'($urandom());
            cycle();
        end

        for (int i = 0; i < NREQ; i++) chk("sb_taken", dut_taken[i], mdl_taken[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
